// File: rtl/writeback.sv
// MEM/WB pipeline register plus the register bank it commits to, with
// write-through bypass on decode's two combinational read ports.
module writeback #(
  parameter int DATA_W = 32,
  parameter int NREG   = 32,
  parameter int ADDR_W = 5
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_stall,
  input  logic              i_flush,
  input  logic              i_con_WrBack,
  input  logic              i_con_MemToReg,
  input  logic              i_con_Link,
  input  logic [ADDR_W-1:0] i_addr_Rd,
  input  logic [DATA_W-1:0] i_data_Alu,
  input  logic [DATA_W-1:0] i_data_Mem,
  input  logic [DATA_W-1:0] i_addr_IncrePC,
  input  logic [ADDR_W-1:0] i_addr_Rs,
  input  logic [ADDR_W-1:0] i_addr_Rt,
  output logic [DATA_W-1:0] o_data_Rs,
  output logic [DATA_W-1:0] o_data_Rt,
  output logic              o_con_WrBack,
  output logic [ADDR_W-1:0] o_addr_Wr,
  output logic [DATA_W-1:0] o_data_Wr
);

  logic              wb_q, wb_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] bank_q [NREG];
  logic [DATA_W-1:0] bank_d [NREG];
  logic [ADDR_W-1:0] eff_rd;
  logic [DATA_W-1:0] result;

  // MEM/WB capture: flush beats stall beats capture
  always_comb begin
    eff_rd = i_con_Link ? ADDR_W'(NREG - 1) : i_addr_Rd;
    if (i_con_Link)
      result = i_addr_IncrePC + DATA_W'(4);
    else if (i_con_MemToReg)
      result = i_data_Mem;
    else
      result = i_data_Alu;

    wb_d   = wb_q;
    addr_d = addr_q;
    data_d = data_q;
    if (i_flush) begin
      wb_d   = 1'b0;
      addr_d = '0;
      data_d = '0;
    end else if (!i_stall) begin
      wb_d   = i_con_WrBack && (eff_rd != '0);
      addr_d = eff_rd;
      data_d = result;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wb_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      wb_q   <= wb_d;
      addr_q <= addr_d;
      data_q <= data_d;
    end
  end

  // Bank commit from the registered stage; entry 0 is pinned to zero
  always_comb begin
    bank_d = bank_q;
    if (wb_q && (addr_q != '0))
      bank_d[addr_q] = data_q;
    bank_d[0] = '0;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NREG; i++)
        bank_q[i] <= '0;
    end else begin
      bank_q <= bank_d;
    end
  end

  // Bypass covers the cycle before the bank write lands
  assign o_data_Rs = (i_addr_Rs == '0) ? '0 :
                     (wb_q && (addr_q == i_addr_Rs)) ? data_q : bank_q[i_addr_Rs];
  assign o_data_Rt = (i_addr_Rt == '0) ? '0 :
                     (wb_q && (addr_q == i_addr_Rt)) ? data_q : bank_q[i_addr_Rt];

  assign o_con_WrBack = wb_q;
  assign o_addr_Wr    = addr_q;
  assign o_data_Wr    = data_q;

endmodule

// File: tb/tb_writeback.sv
// Directed and randomized bench for writeback; the model is an architectural
// register file that reflects each instruction as soon as it is captured.
module tb_writeback;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0, flush = 1'b0;
  logic        wb = 1'b0, m2r = 1'b0, link = 1'b0;
  logic [4:0]  rd = '0, rs = '0, rt = '0;
  logic [31:0] alu = '0, mem = '0, pc = '0;
  logic [31:0] data_rs, data_rt, data_wr;
  logic        wb_out;
  logic [4:0]  addr_wr;

  int checks = 0;
  int errors = 0;

  logic [31:0] arch [32];
  logic        exp_wb;
  logic [4:0]  exp_addr;
  logic [31:0] exp_data;

  writeback #(.DATA_W(32), .NREG(32), .ADDR_W(5)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_stall(stall), .i_flush(flush),
    .i_con_WrBack(wb), .i_con_MemToReg(m2r), .i_con_Link(link),
    .i_addr_Rd(rd), .i_data_Alu(alu), .i_data_Mem(mem), .i_addr_IncrePC(pc),
    .i_addr_Rs(rs), .i_addr_Rt(rt),
    .o_data_Rs(data_rs), .o_data_Rt(data_rt),
    .o_con_WrBack(wb_out), .o_addr_Wr(addr_wr), .o_data_Wr(data_wr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) arch[i] = '0;
    exp_wb = 1'b0; exp_addr = '0; exp_data = '0;
  endtask

  // Drive one instruction, clock it in and update the architectural model
  task automatic cycle(input logic f, input logic s, input logic w, input logic m,
                       input logic l, input logic [4:0] d, input logic [31:0] a,
                       input logic [31:0] md, input logic [31:0] p);
    logic [4:0] eff;
    flush = f; stall = s; wb = w; m2r = m; link = l; rd = d; alu = a; mem = md; pc = p;
    @(posedge clk); #1;
    if (f) begin
      exp_wb = 1'b0; exp_addr = '0; exp_data = '0;
    end else if (!s) begin
      eff      = l ? 5'd31 : d;
      exp_addr = eff;
      exp_data = l ? p + 32'd4 : (m ? md : a);
      exp_wb   = w && (eff != 5'd0);
      if (exp_wb) arch[eff] = exp_data;
    end
    chk("o_con_WrBack", {31'd0, wb_out}, {31'd0, exp_wb});
    chk("o_addr_Wr", {27'd0, addr_wr}, {27'd0, exp_addr});
    chk("o_data_Wr", data_wr, exp_data);
  endtask

  task automatic rd_chk(input logic [4:0] a, input logic [4:0] b);
    rs = a; rt = b; #1;
    chk("o_data_Rs", data_rs, (a == 0) ? 32'd0 : arch[a]);
    chk("o_data_Rt", data_rt, (b == 0) ? 32'd0 : arch[b]);
  endtask

  task automatic nop();
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 32'd0);
  endtask

  initial begin
    model_reset();
    #12 rst_n = 1'b1;
    #1;
    chk("reset_wb", {31'd0, wb_out}, 32'd0);
    chk("reset_data", data_wr, 32'd0);
    rd_chk(5'd5, 5'd31);

    // ALU path, bypass then bank
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd5, 32'hDEADBEEF, 32'h0, 32'h0);
    rd_chk(5'd5, 5'd5);
    chk("alu_bypass_r5", data_rs, 32'hDEADBEEF);
    nop(); rd_chk(5'd5, 5'd0);
    chk("alu_bank_r5", data_rs, 32'hDEADBEEF);

    // Load path
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd6, 32'h11111111, 32'hCAFEF00D, 32'h0);
    rd_chk(5'd6, 5'd5);
    nop(); rd_chk(5'd6, 5'd6);
    chk("load_r6", data_rt, 32'hCAFEF00D);

    // r0 never becomes writable
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'hFFFFFFFF, 32'h0, 32'h0);
    chk("r0_wb", {31'd0, wb_out}, 32'd0);
    rd_chk(5'd0, 5'd0);
    nop(); rd_chk(5'd0, 5'd6);

    // Link: first a normal value, then the wrapping one
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd3, 32'h5, 32'h6, 32'h00000100);
    rd_chk(5'd31, 5'd3);
    chk("link_r31", data_rs, 32'h00000104);
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 5'd3, 32'h5, 32'h6, 32'hFFFFFFFC);
    rd_chk(5'd31, 5'd31);
    chk("link_wrap", data_rs, 32'h0);
    nop(); rd_chk(5'd31, 5'd3);

    // Stall holds the stage while inputs change
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd7, 32'h00000777, 32'h0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b1, 1'b1, i[0], 1'b0, 5'(8 + i), $urandom, $urandom, $urandom);
      rd_chk(5'd7, 5'(8 + i));
      chk("stall_r7", data_rs, 32'h00000777);
    end
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd10, 32'hABCD, 32'h0, 32'h0);
    chk("flush_over_stall", {31'd0, wb_out}, 32'd0);
    rd_chk(5'd7, 5'd10);

    // Same-register hazard
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd9, 32'd1, 32'h0, 32'h0);
    rd_chk(5'd9, 5'd9);
    chk("hazard_first", data_rs, 32'd1);
    chk("hazard_ports_eq1", data_rt, data_rs);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd9, 32'd2, 32'h0, 32'h0);
    rd_chk(5'd9, 5'd9);
    chk("hazard_second", data_rs, 32'd2);
    nop(); rd_chk(5'd9, 5'd9);
    chk("hazard_ports_eq2", data_rt, 32'd2);

    // Reset with r5 holding a committed value
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd5, 32'h00001234, 32'h0, 32'h0);
    nop();
    rd_chk(5'd5, 5'd5);
    #2 rst_n = 1'b0; #1;
    model_reset();
    chk("rst_async_wb", {31'd0, wb_out}, 32'd0);
    chk("rst_async_data", data_wr, 32'd0);
    rd_chk(5'd5, 5'd5);
    @(negedge clk) rst_n = 1'b1;
    rd_chk(5'd5, 5'd9);

    // Reset arriving while a write is pending aborts it
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd12, 32'h5A5A5A5A, 32'h0, 32'h0);
    rst_n = 1'b0; #1;
    model_reset();
    rd_chk(5'd12, 5'd12);
    @(negedge clk) rst_n = 1'b1;
    nop(); rd_chk(5'd12, 5'd0);

    // Randomized traffic
    for (int n = 0; n < 300; n++) begin
      cycle(($urandom_range(0, 15) == 0), ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 3) != 0), $urandom_range(0, 1),
            ($urandom_range(0, 9) == 0), 5'($urandom_range(0, 31)),
            $urandom, $urandom, $urandom);
      rd_chk(5'($urandom_range(0, 31)), (n % 4 == 0) ? addr_wr : 5'($urandom_range(0, 31)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
